// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM state type and counter width helpers for conv_tap_sequencer
package conv_pkg;

  typedef enum logic {LOAD, EMIT} tap_state_t;

  // Width that can index 0..n-1, never below one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_width(input int img_w);
    return ctr_width(img_w);
  endfunction

  function automatic int row_width(input int img_h);
    return ctr_width(img_h);
  endfunction

  function automatic int tap_width(input int k);
    return ctr_width(k);
  endfunction

endpackage

// File: rtl/row_ring_buffer.sv
// rtl/row_ring_buffer.sv - K row slots of IMG_W pixel vectors, one sync write port, one comb read port
module row_ring_buffer #(
  parameter int K     = 3,
  parameter int IMG_W = 8,
  parameter int W     = 128,
  parameter int SW    = 2,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  logic [CW-1:0] wr_col,
  input  logic [W-1:0]  wr_data,
  input  logic [SW-1:0] rd_slot,
  input  logic [CW-1:0] rd_col,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [K][IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_slot][wr_col] <= wr_data;
  end

  assign rd_data = mem[rd_slot][rd_col];

endmodule

// File: rtl/conv_tap_sequencer.sv
// rtl/conv_tap_sequencer.sv - buffers K image rows and replays each KxK window one tap per cycle
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int KERNAL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 8,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DEPTH*DATA_WIDTH-1:0]   neuron_in,
  output logic [KERNAL_SIZE**2-1:0]     count,
  output logic                          tap_last,
  output logic                          frame_done
);

  localparam int K      = KERNAL_SIZE;
  localparam int W      = DEPTH * DATA_WIDTH;
  localparam int CW     = col_width(IMG_W);
  localparam int RW     = row_width(IMG_H);
  localparam int TW     = tap_width(K);
  localparam int CNT_W  = K * K;
  localparam int LAST_C = IMG_W - K;
  localparam int LAST_B = IMG_H - K;

  tap_state_t state, state_d;
  logic [CW-1:0]    col, col_d, c, c_d, nc, rd_col;
  logic [RW-1:0]    row, row_d, b, b_d;
  logic [TW-1:0]    wr_slot, wr_slot_d, base_slot, base_slot_d;
  logic [TW-1:0]    ky, ky_d, kx, kx_d, nky, nkx, rd_slot;
  logic             in_ready_d, out_valid_d, tap_last_d, frame_done_d;
  logic [W-1:0]     neuron_d, rd_data;
  logic [CNT_W-1:0] count_d;
  logic             acc, take, is_last, band_full;
  int               rd_sum;

  assign acc       = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign is_last   = (int'(c) == LAST_C) && (int'(ky) == K - 1) && (int'(kx) == K - 1);
  assign band_full = acc && (int'(col) == IMG_W - 1) && (int'(row) == int'(b) + K - 1);

  // Address of the tap presented after the next update; (b, col 0) while loading.
  always_comb begin
    nc  = '0;
    nky = '0;
    nkx = '0;
    if (state == EMIT) begin
      nc  = c;
      nky = ky;
      nkx = kx + 1'b1;
      if (kx == TW'(K - 1)) begin
        nkx = '0;
        nky = ky + 1'b1;
        if (ky == TW'(K - 1)) begin
          nky = '0;
          nc  = c + 1'b1;
        end
      end
    end
    rd_sum = int'(base_slot) + int'(nky);
    if (rd_sum >= K) rd_sum = rd_sum - K;
    rd_slot = TW'(rd_sum);
    rd_col  = CW'(int'(nc) + int'(nkx));
  end

  row_ring_buffer #(
    .K     (K),
    .IMG_W (IMG_W),
    .W     (W),
    .SW    (TW),
    .CW    (CW)
  ) u_ring (
    .clk     (clk),
    .wr_en   (acc),
    .wr_slot (wr_slot),
    .wr_col  (col),
    .wr_data (in_data),
    .rd_slot (rd_slot),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state;
    col_d        = col;
    row_d        = row;
    wr_slot_d    = wr_slot;
    b_d          = b;
    base_slot_d  = base_slot;
    c_d          = c;
    ky_d         = ky;
    kx_d         = kx;
    neuron_d     = neuron_in;
    count_d      = count;
    tap_last_d   = tap_last;
    frame_done_d = 1'b0;
    case (state)
      LOAD: begin
        if (acc) begin
          col_d = col + 1'b1;
          if (col == CW'(IMG_W - 1)) begin
            col_d     = '0;
            row_d     = row + 1'b1;
            wr_slot_d = (wr_slot == TW'(K - 1)) ? '0 : wr_slot + 1'b1;
          end
          if (band_full) begin
            state_d    = EMIT;
            c_d        = '0;
            ky_d       = '0;
            kx_d       = '0;
            neuron_d   = rd_data;
            count_d    = '0;
            tap_last_d = 1'b0;
          end
        end
      end
      EMIT: begin
        if (take) begin
          if (is_last) begin
            state_d = LOAD;
            if (b == RW'(LAST_B)) begin
              b_d          = '0;
              base_slot_d  = '0;
              row_d        = '0;
              col_d        = '0;
              wr_slot_d    = '0;
              frame_done_d = 1'b1;
            end else begin
              b_d         = b + 1'b1;
              base_slot_d = (base_slot == TW'(K - 1)) ? '0 : base_slot + 1'b1;
            end
          end else begin
            c_d        = nc;
            ky_d       = nky;
            kx_d       = nkx;
            neuron_d   = rd_data;
            count_d    = CNT_W'(int'(nky) * K + int'(nkx));
            tap_last_d = (nky == TW'(K - 1)) && (nkx == TW'(K - 1));
          end
        end
      end
      default: state_d = LOAD;
    endcase
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      col        <= '0;
      row        <= '0;
      wr_slot    <= '0;
      b          <= '0;
      base_slot  <= '0;
      c          <= '0;
      ky         <= '0;
      kx         <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      neuron_in  <= '0;
      count      <= '0;
      tap_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      col        <= col_d;
      row        <= row_d;
      wr_slot    <= wr_slot_d;
      b          <= b_d;
      base_slot  <= base_slot_d;
      c          <= c_d;
      ky         <= ky_d;
      kx         <= kx_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      neuron_in  <= neuron_d;
      count      <= count_d;
      tap_last   <= tap_last_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: doc/conv_tap_sequencer.md
# conv_tap_sequencer

Upstream feeder for `conv_node`. Accepts a raster-order stream of DEPTH-channel pixel vectors, holds the last KERNAL_SIZE image rows in a ring of row buffers, and replays each KERNAL_SIZE×KERNAL_SIZE window one kernel tap per cycle. Output is valid-only "valid" convolution with stride 1. Each emitted tap carries the `count` index that `conv_node` uses to select the weight and detect the kernel shift.

## Interface
- KERNAL_SIZE, 3: kernel edge length K (≥2).
- DATA_WIDTH, 16: bits per channel sample.
- DEPTH, 8: channels per pixel vector.
- IMG_W, 8: image width in pixels (≥K).
- IMG_H, 8: image height in pixels (≥K).
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low (reset==0 clears all state immediately).
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  block accepts a pixel; transfer when in_valid && in_ready.
- in_data  in  DEPTH*DATA_WIDTH  pixel vector; channel i at [i*DATA_WIDTH+:DATA_WIDTH].
- out_valid  out  1  tap valid.
- out_ready  in  1  downstream accepts the tap.
- neuron_in  out  DEPTH*DATA_WIDTH  pixel vector at the current tap.
- count  out  KERNAL_SIZE**2  tap index ky*K+kx, zero-extended.
- tap_last  out  1  high on the final tap (count==K*K-1) of each window.
- frame_done  out  1  one-cycle pulse after the last tap of a frame.

## Operation
- Storage: K row slots × IMG_W entries. Image row r lives in slot r mod K.
- Phases are exclusive. `in_ready` and `out_valid` are never high in the same cycle.
- LOAD state: `in_ready`=1. Each accepted pixel is written to slot (row mod K) at column col, then col++. At col==IMG_W-1, col wraps to 0 and row++.
  - Band 0 needs rows 0..K-1, so K*IMG_W pixels.
  - Band b>0 needs one new row, b+K-1, so IMG_W pixels.
  - The block leaves LOAD on acceptance of the last pixel the band needs.
- EMIT state: `out_valid`=1. Output column c runs 0..IMG_W-K; for each column, ky runs 0..K-1 (outer) and kx runs 0..K-1 (inner).
  - `neuron_in` = pixel at row b+ky, column c+kx, read from slot (b+ky) mod K.
  - `count` = ky*K+kx.
  - Tap indices advance only on an out_valid && out_ready handshake.
- End of band: after the handshake on the last tap of column IMG_W-K:
  - If b < IMG_H-K: b++ and go to LOAD.
  - Otherwise go to LOAD with row, col and b cleared, and pulse `frame_done`.
- The next frame starts on the next accepted pixel. No start signal.

## Timing
- Reset values: in_ready=0, out_valid=0, neuron_in=0, count=0, tap_last=0, frame_done=0. State goes to LOAD and all counters clear. Buffer contents are undefined and never read before being written.
- First cycle after reset deasserts: in_ready=1.
- All outputs are registered.
  - `out_valid` rises exactly 1 cycle after the handshake of a band's final load pixel, with the first tap already presented.
  - `in_ready` rises 1 cycle after the handshake of a band's final tap.
- Throughput: 1 tap/cycle while out_ready=1.
- With out_ready=0, `neuron_in`, `count` and `tap_last` hold stable.
- `frame_done` is high in the cycle `in_ready` re-rises after the final band.
- Per frame: (IMG_W-K+1)*(IMG_H-K+1)*K*K taps and IMG_W*IMG_H pixels accepted.
- Reset asserted mid-LOAD or mid-EMIT: the partial frame is discarded and outputs return to reset values asynchronously.

## Structure
- Package `conv_pkg`:
  - `tap_state_t` enum {LOAD, EMIT}.
  - localparam functions for counter widths: $clog2(IMG_W), $clog2(IMG_H), $clog2(K).
- Sub-module `row_ring_buffer`: K×IMG_W×(DEPTH*DATA_WIDTH) flop array with one synchronous write port (slot, col) and one combinational read port (slot, col).
- The top level holds the FSM, the load counters (row, col), the emit counters (b, c, ky, kx) and the output registers.

## Test plan
- K=3, IMG_W=5, IMG_H=4, DEPTH=2, each pixel channel = row*16+col, out_ready=1 -> 54 taps. First window values are 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22 with count 0..8 and tap_last on count 8. The last window starts at 0x12. frame_done pulses once.
- Same frame with random out_ready toggling -> identical tap sequence; outputs hold stable on every stalled cycle.
- Band transition: after the 3 windows of band 0 -> in_ready re-rises and exactly 5 pixels (row 3) are accepted. Band 1's first tap is 0x10, read from slot 1, and row 3 overwrites slot 0.
- Two back-to-back frames -> the second frame's first tap equals its own pixel (0,0), with no stale data from frame 1.
- Reset pulled low mid-EMIT at tap 20 -> out_valid=0, count=0 immediately. After release, a full new frame produces the correct 54 taps.
- in_valid=0 gaps during LOAD -> no accepted-pixel count advance, out_valid stays 0 until the 15th pixel is accepted.
